// File: rtl/axis_deadlock_monitor.sv
// axis_deadlock_monitor
// Watches a set of AXI-Stream channels and declares a deadlock once at least
// one monitored, non-idle channel has been blocked for THRESHOLD consecutive
// cycles. The declaration is sticky until cleared and carries a snapshot of
// the blocked channels plus a saturating count of cycles spent deadlocked.

module axis_deadlock_monitor #(
  parameter int NUM_CH    = 4,
  parameter int THRESHOLD = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] axis_block_sigs,
  input  logic [NUM_CH-1:0] inst_idle_sigs,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              clear,
  output logic              block,
  output logic [NUM_CH-1:0] axis_block_info,
  output logic [4:0]        first_ch,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Run counter must be able to hold the value THRESHOLD itself.
  localparam int RUN_W = $clog2(THRESHOLD + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(THRESHOLD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  state_t           state;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_inc;
  logic [NUM_CH-1:0] blk_vec;
  logic              any_blk;
  logic [4:0]        blk_first;

  // Lowest set bit of a channel vector; zero when the vector is empty.
  function automatic logic [4:0] lowest_idx(input logic [NUM_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Qualify raw block flags: only monitored, non-idle channels count.
  always_comb begin
    blk_vec   = axis_block_sigs & ch_mask & ~inst_idle_sigs;
    any_blk   = |blk_vec;
    blk_first = lowest_idx(blk_vec);
    run_inc   = run_cnt + RUN_W'(1);
  end

  // Detection FSM; every output is a flop written alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      run_cnt         <= '0;
      block           <= 1'b0;
      axis_block_info <= '0;
      first_ch        <= '0;
      stall_cycles    <= '0;
    end else if (clear) begin
      state           <= IDLE;
      run_cnt         <= '0;
      block           <= 1'b0;
      axis_block_info <= '0;
      first_ch        <= '0;
      stall_cycles    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_blk) begin
            run_cnt <= RUN_W'(1);
            if (THRESHOLD == 1) begin
              state           <= DEADLOCK;
              block           <= 1'b1;
              axis_block_info <= blk_vec;
              first_ch        <= blk_first;
              stall_cycles    <= '0;
            end else begin
              state <= SUSPECT;
            end
          end else begin
            run_cnt <= '0;
          end
        end

        SUSPECT: begin
          if (!any_blk) begin
            state   <= IDLE;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_inc;
            if (run_inc == RUN_LIMIT) begin
              state           <= DEADLOCK;
              block           <= 1'b1;
              axis_block_info <= blk_vec;
              first_ch        <= blk_first;
              stall_cycles    <= '0;
            end
          end
        end

        DEADLOCK: begin
          block <= 1'b1;
          if (stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
          end
        end

        default: begin
          state           <= IDLE;
          run_cnt         <= '0;
          block           <= 1'b0;
          axis_block_info <= '0;
          first_ch        <= '0;
          stall_cycles    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_deadlock_monitor.sv
// Testbench for axis_deadlock_monitor: directed scenarios, expected outputs
// queued as each cycle is driven and compared once the edge has been taken.

module tb_axis_deadlock_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [3:0]  axis_block_sigs, inst_idle_sigs, ch_mask;
  logic        clear;
  logic        block;
  logic [3:0]  axis_block_info;
  logic [4:0]  first_ch;
  logic [15:0] stall_cycles;

  logic [3:0]  t1_block_sigs, t1_idle_sigs, t1_mask;
  logic        t1_clear;
  logic        t1_block;
  logic [3:0]  t1_info;
  logic [4:0]  t1_first;
  logic [15:0] t1_stall;

  logic        t2_block;
  logic [3:0]  t2_info;
  logic [4:0]  t2_first;
  logic [1:0]  t2_stall;

  axis_deadlock_monitor #(.NUM_CH(4), .THRESHOLD(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
    .ch_mask(ch_mask), .clear(clear),
    .block(block), .axis_block_info(axis_block_info),
    .first_ch(first_ch), .stall_cycles(stall_cycles)
  );

  axis_deadlock_monitor #(.NUM_CH(4), .THRESHOLD(1), .CNT_W(16)) dut_t1 (
    .clock(clock), .reset(reset),
    .axis_block_sigs(t1_block_sigs), .inst_idle_sigs(t1_idle_sigs),
    .ch_mask(t1_mask), .clear(t1_clear),
    .block(t1_block), .axis_block_info(t1_info),
    .first_ch(t1_first), .stall_cycles(t1_stall)
  );

  // Same stimulus as dut_t1 but a 2-bit stall counter to reach saturation.
  axis_deadlock_monitor #(.NUM_CH(4), .THRESHOLD(1), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset),
    .axis_block_sigs(t1_block_sigs), .inst_idle_sigs(t1_idle_sigs),
    .ch_mask(t1_mask), .clear(t1_clear),
    .block(t2_block), .axis_block_info(t2_info),
    .first_ch(t2_first), .stall_cycles(t2_stall)
  );

  typedef struct {
    logic        blk;
    logic [3:0]  info;
    logic [4:0]  first;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int vectors = 0;
  int miscompares = 0;

  function automatic exp_t mk(logic b, logic [3:0] i, logic [4:0] f, logic [15:0] s);
    exp_t r;
    r.blk = b; r.info = i; r.first = f; r.stall = s;
    return r;
  endfunction

  function automatic exp_t quiet();
    return mk(1'b0, 4'd0, 5'd0, 16'd0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b1;
    axis_block_sigs = 4'hF; inst_idle_sigs = 4'h0; ch_mask = 4'hF;
    t1_block_sigs = 4'hF; t1_idle_sigs = 4'h0; t1_mask = 4'hF; t1_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles, t1_block, t1_stall} !==
          {e.blk, e.info, e.first, e.stall, 1'b0, 16'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset k=%0d: got blk=%b info=%b first=%0d stall=%0d t1blk=%b, expected all zero",
                 k, block, axis_block_info, first_ch, stall_cycles, t1_block);
      end
    end
    reset = 1'b0; clear = 1'b0;
    axis_block_sigs = 4'h0;
    t1_block_sigs = 4'h0;
    tick();
  endtask

  task automatic test_basic();
    for (int k = 1; k <= 13; k++) begin
      clear = (k == 13);
      axis_block_sigs = (k <= 8) ? 4'b0100 : 4'b0011;
      if (k == 13)     exp_q.push_back(quiet());
      else if (k >= 8) exp_q.push_back(mk(1'b1, 4'b0100, 5'd2, 16'(k - 8)));
      else             exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL basic k=%0d: got blk=%b info=%b first=%0d stall=%0d, expected blk=%b info=%b first=%0d stall=%0d",
                 k, block, axis_block_info, first_ch, stall_cycles, e.blk, e.info, e.first, e.stall);
      end
    end
    clear = 1'b0;
    axis_block_sigs = 4'h0;
  endtask

  task automatic test_no_partial_credit();
    for (int k = 1; k <= 15; k++) begin
      axis_block_sigs = (k == 8) ? 4'b0000 : 4'b0001;
      exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL partial k=%0d: got blk=%b stall=%0d, expected blk=0 stall=0",
                 k, block, stall_cycles);
      end
    end
    axis_block_sigs = 4'h0;
    tick();
  endtask

  task automatic test_idle_filter();
    inst_idle_sigs = 4'b0010;
    for (int k = 1; k <= 21; k++) begin
      clear = (k == 21);
      axis_block_sigs = (k <= 20) ? 4'b1010 : 4'b0000;
      if (k >= 8 && k <= 20) exp_q.push_back(mk(1'b1, 4'b1000, 5'd3, 16'(k - 8)));
      else                   exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL idle_filter k=%0d: got blk=%b info=%b first=%0d stall=%0d, expected blk=%b info=%b first=%0d stall=%0d",
                 k, block, axis_block_info, first_ch, stall_cycles, e.blk, e.info, e.first, e.stall);
      end
    end
    clear = 1'b0;
    // Channel blocked but marked idle must never be detected.
    inst_idle_sigs = 4'b0100;
    axis_block_sigs = 4'b0100;
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, stall_cycles} !== {e.blk, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL idle_only k=%0d: got blk=%b, expected blk=0", k, block);
      end
    end
    inst_idle_sigs = 4'h0;
    axis_block_sigs = 4'h0;
    tick();
  endtask

  task automatic test_mask();
    // 5 blocked, 1 masked (drops back to IDLE), then 8 blocked to detect.
    for (int k = 1; k <= 15; k++) begin
      clear = (k == 15);
      axis_block_sigs = 4'b0001;
      ch_mask = (k == 6) ? 4'b1110 : 4'hF;
      if (k == 14) exp_q.push_back(mk(1'b1, 4'b0001, 5'd0, 16'd0));
      else         exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL mask k=%0d: got blk=%b info=%b stall=%0d, expected blk=%b info=%b stall=%0d",
                 k, block, axis_block_info, stall_cycles, e.blk, e.info, e.stall);
      end
    end
    clear = 1'b0;
    ch_mask = 4'hF;
    axis_block_sigs = 4'h0;
    tick();
  endtask

  task automatic test_clear();
    axis_block_sigs = 4'b0001;
    // k 1..10 detect, k 11 clear while still blocked, k 12..20 re-detect.
    for (int k = 1; k <= 20; k++) begin
      clear = (k == 11);
      if (k >= 8 && k <= 10)  exp_q.push_back(mk(1'b1, 4'b0001, 5'd0, 16'(k - 8)));
      else if (k >= 19)       exp_q.push_back(mk(1'b1, 4'b0001, 5'd0, 16'(k - 19)));
      else                    exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL clear k=%0d: got blk=%b info=%b stall=%0d, expected blk=%b info=%b stall=%0d",
                 k, block, axis_block_info, stall_cycles, e.blk, e.info, e.stall);
      end
    end
    clear = 1'b1;
    axis_block_sigs = 4'h0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset_mid();
    axis_block_sigs = 4'b0100;
    // k 5 is reset during SUSPECT; k 13 detects; k 16 is reset during DEADLOCK.
    for (int k = 1; k <= 18; k++) begin
      reset = (k == 5 || k == 16);
      clear = (k == 5);
      if (k >= 17) axis_block_sigs = 4'b0000;
      if (k >= 13 && k <= 15) exp_q.push_back(mk(1'b1, 4'b0100, 5'd2, 16'(k - 13)));
      else                    exp_q.push_back(quiet());
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({block, axis_block_info, first_ch, stall_cycles} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL reset_mid k=%0d: got blk=%b info=%b first=%0d stall=%0d, expected blk=%b info=%b first=%0d stall=%0d",
                 k, block, axis_block_info, first_ch, stall_cycles, e.blk, e.info, e.first, e.stall);
      end
    end
    reset = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_threshold_one();
    for (int k = 1; k <= 7; k++) begin
      t1_clear = (k == 7);
      t1_block_sigs = (k == 1) ? 4'b0001 : 4'b0000;
      if (k == 7) exp_q.push_back(quiet());
      else        exp_q.push_back(mk(1'b1, 4'b0001, 5'd0, 16'(k - 1)));
      tick();
      e = exp_q.pop_front();
      vectors++;
      if ({t1_block, t1_info, t1_first, t1_stall} !== {e.blk, e.info, e.first, e.stall}) begin
        miscompares++;
        $display("[TB] FAIL thr1 k=%0d: got blk=%b info=%b first=%0d stall=%0d, expected blk=%b info=%b first=%0d stall=%0d",
                 k, t1_block, t1_info, t1_first, t1_stall, e.blk, e.info, e.first, e.stall);
      end
      vectors++;
      if ({t2_block, t2_info, t2_stall} !== {e.blk, e.info, (e.stall > 16'd3) ? 2'd3 : e.stall[1:0]}) begin
        miscompares++;
        $display("[TB] FAIL sat k=%0d: got blk=%b info=%b stall=%0d, expected blk=%b info=%b stall=%0d",
                 k, t2_block, t2_info, t2_stall, e.blk, e.info, (e.stall > 16'd3) ? 16'd3 : e.stall);
      end
    end
    t1_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_partial_credit();
    test_idle_filter();
    test_mask();
    test_clear();
    test_reset_mid();
    test_threshold_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
